// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared core package for the writeback controller.
// Holds the default register width and count, the derived address width and the
// pending-counter width used by the scoreboard.
package regfile_wb_ctrl_pkg;

    localparam int unsigned BIT_DEFAULT     = 32;
    localparam int unsigned REG_NUM_DEFAULT = 32;
    localparam int unsigned AW_DEFAULT      = $clog2(REG_NUM_DEFAULT);

    // Pending counter per register; saturates at PEND_MAX outstanding writes.
    localparam int unsigned       PEND_W   = 2;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

endpackage

// File: rtl/regfile_wb_ctrl_scoreboard.sv
// wb_scoreboard: per-register pending-write counters, hazard query and the sticky
// underflow flag.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   inc_en, inc_addr     - reserve a destination (increment)
//   dec_en, dec_addr     - retire a write (decrement)
//   full_addr, full      - full=1 when full_addr!=0 and its counter is saturated
//   chk_rs1, chk_rs2     - operand addresses to query
//   hazard               - any nonzero queried operand has a pending write
//   sb_err               - set on decrement of a zero counter, held until reset
module wb_scoreboard
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int unsigned REG_NUM = REG_NUM_DEFAULT,
    localparam int unsigned AW     = $clog2(REG_NUM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_en,
    input  logic [AW-1:0] inc_addr,
    input  logic          dec_en,
    input  logic [AW-1:0] dec_addr,
    input  logic [AW-1:0] full_addr,
    output logic          full,
    input  logic [AW-1:0] chk_rs1,
    input  logic [AW-1:0] chk_rs2,
    output logic          hazard,
    output logic          sb_err
);

    logic [PEND_W-1:0] cnt_q [REG_NUM];
    logic [PEND_W-1:0] cnt_d [REG_NUM];
    logic              err_d;

    always_comb begin
        cnt_d    = cnt_q;
        err_d    = sb_err;
        cnt_d[0] = '0;
        for (int i = 1; i < REG_NUM; i++) begin
            // Simultaneous reserve and retire of one register cancel out.
            if (inc_en && inc_addr == AW'(i) && !(dec_en && dec_addr == AW'(i))) begin
                if (cnt_q[i] != PEND_MAX) begin
                    cnt_d[i] = cnt_q[i] + PEND_W'(1);
                end
            end else if (dec_en && dec_addr == AW'(i) && !(inc_en && inc_addr == AW'(i))) begin
                if (cnt_q[i] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - PEND_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                cnt_q[i] <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sb_err <= err_d;
        end
    end

    assign full   = (full_addr != '0) && (cnt_q[full_addr] == PEND_MAX);
    assign hazard = ((chk_rs1 != '0) && (cnt_q[chk_rs1] != '0)) ||
                    ((chk_rs2 != '0) && (cnt_q[chk_rs2] != '0));

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback controller.
// Arbitrates two writeback requesters (A: ALU, B: load) round-robin into a single
// registered regfile write port and tracks pending destinations in a scoreboard.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   iss_valid, iss_rd, iss_ready     - destination reservation at issue
//   a_valid, a_rd, a_data, a_ready   - ALU writeback request
//   b_valid, b_rd, b_data, b_ready   - load writeback request
//   wr_en, wr_addr, wr_data          - registered regfile write port (1-cycle latency)
//   chk_rs1, chk_rs2, hazard         - read-operand hazard query
//   sb_err                           - sticky scoreboard underflow flag
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int unsigned BIT     = BIT_DEFAULT,
    parameter int unsigned REG_NUM = REG_NUM_DEFAULT,
    localparam int unsigned AW     = $clog2(REG_NUM)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           iss_valid,
    input  logic [AW-1:0]  iss_rd,
    output logic           iss_ready,
    input  logic           a_valid,
    input  logic [AW-1:0]  a_rd,
    input  logic [BIT-1:0] a_data,
    output logic           a_ready,
    input  logic           b_valid,
    input  logic [AW-1:0]  b_rd,
    input  logic [BIT-1:0] b_data,
    output logic           b_ready,
    output logic           wr_en,
    output logic [AW-1:0]  wr_addr,
    output logic [BIT-1:0] wr_data,
    input  logic [AW-1:0]  chk_rs1,
    input  logic [AW-1:0]  chk_rs2,
    output logic           hazard,
    output logic           sb_err
);

    logic iss_full;
    logic inc_en;
    logic favor_b_q;  // B wins the next contention

    assign iss_ready = !iss_full;
    assign inc_en    = iss_valid && iss_ready && (iss_rd != '0);

    // Grants are suppressed during reset so no handshake completes in that cycle.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst) begin
            if (a_valid && b_valid) begin
                a_ready = !favor_b_q;
                b_ready = favor_b_q;
            end else begin
                a_ready = a_valid;
                b_ready = b_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            favor_b_q <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            if (a_valid && b_valid) begin
                favor_b_q <= a_ready;
            end
            wr_en <= 1'b0;
            if (a_ready) begin
                wr_en   <= (a_rd != '0);
                wr_addr <= a_rd;
                wr_data <= a_data;
            end else if (b_ready) begin
                wr_en   <= (b_rd != '0);
                wr_addr <= b_rd;
                wr_data <= b_data;
            end
        end
    end

    // Retire on the edge that ends the write cycle, so hazard drops one cycle later.
    wb_scoreboard #(
        .REG_NUM (REG_NUM)
    ) u_wb_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .inc_en    (inc_en),
        .inc_addr  (iss_rd),
        .dec_en    (wr_en),
        .dec_addr  (wr_addr),
        .full_addr (iss_rd),
        .full      (iss_full),
        .chk_rs1   (chk_rs1),
        .chk_rs2   (chk_rs2),
        .hazard    (hazard),
        .sb_err    (sb_err)
    );

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed scenarios plus a randomized
// run compared against a behavioural model of pending counts and writebacks.
module tb_regfile_wb_ctrl;

    localparam int BIT     = 32;
    localparam int REG_NUM = 32;
    localparam int AW      = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           iss_valid;
    logic [AW-1:0]  iss_rd;
    logic           iss_ready;
    logic           a_valid;
    logic [AW-1:0]  a_rd;
    logic [BIT-1:0] a_data;
    logic           a_ready;
    logic           b_valid;
    logic [AW-1:0]  b_rd;
    logic [BIT-1:0] b_data;
    logic           b_ready;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [BIT-1:0] wr_data;
    logic [AW-1:0]  chk_rs1;
    logic [AW-1:0]  chk_rs2;
    logic           hazard;
    logic           sb_err;

    always #5 clk = ~clk;

    regfile_wb_ctrl #(
        .BIT     (BIT),
        .REG_NUM (REG_NUM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .a_valid   (a_valid),
        .a_rd      (a_rd),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_rd      (b_rd),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .chk_rs1   (chk_rs1),
        .chk_rs2   (chk_rs2),
        .hazard    (hazard),
        .sb_err    (sb_err)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: outstanding write count per register and the expected
    // registered write port contents.
    int             pend [REG_NUM];
    bit             m_err;
    bit             m_favor_b;
    bit             m_wr_en;
    int             m_wr_addr;
    logic [BIT-1:0] m_wr_data;

    // Combinational expectations and DUT samples of the most recent cycle.
    bit   e_iss_ready, e_a_ready, e_b_ready, e_hazard;
    logic s_iss_ready, s_a_ready, s_b_ready, s_hazard;

    task automatic idle();
        rst       = 1'b0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        a_valid   = 1'b0;
        a_rd      = '0;
        a_data    = '0;
        b_valid   = 1'b0;
        b_rd      = '0;
        b_data    = '0;
        chk_rs1   = '0;
        chk_rs2   = '0;
    endtask

    // One clock cycle: sample combinational outputs mid-cycle, advance the model
    // at the rising edge, return just after it.
    task automatic tick();
        int inc_r;
        int dec_r;
        @(negedge clk);
        e_iss_ready = !(iss_rd != 0 && pend[iss_rd] == 3);
        if (rst) begin
            e_a_ready = 1'b0;
            e_b_ready = 1'b0;
        end else if (a_valid && b_valid) begin
            e_a_ready = !m_favor_b;
            e_b_ready = m_favor_b;
        end else begin
            e_a_ready = a_valid;
            e_b_ready = b_valid;
        end
        e_hazard = (chk_rs1 != 0 && pend[chk_rs1] != 0) || (chk_rs2 != 0 && pend[chk_rs2] != 0);
        s_iss_ready = iss_ready;
        s_a_ready   = a_ready;
        s_b_ready   = b_ready;
        s_hazard    = hazard;
        @(posedge clk);
        if (rst) begin
            foreach (pend[i]) pend[i] = 0;
            m_err     = 1'b0;
            m_favor_b = 1'b0;
            m_wr_en   = 1'b0;
            m_wr_addr = 0;
            m_wr_data = '0;
        end else begin
            inc_r = (iss_valid && e_iss_ready && iss_rd != 0) ? int'(iss_rd) : -1;
            dec_r = m_wr_en ? m_wr_addr : -1;
            if (inc_r != dec_r) begin
                if (inc_r > 0 && pend[inc_r] < 3) pend[inc_r]++;
                if (dec_r > 0) begin
                    if (pend[dec_r] == 0) m_err = 1'b1;
                    else pend[dec_r]--;
                end
            end
            if (a_valid && b_valid) m_favor_b = e_a_ready;
            if (e_a_ready) begin
                m_wr_en = (a_rd != 0); m_wr_addr = int'(a_rd); m_wr_data = a_data;
            end else if (e_b_ready) begin
                m_wr_en = (b_rd != 0); m_wr_addr = int'(b_rd); m_wr_data = b_data;
            end else begin
                m_wr_en = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        chk_rs1 = 5'd5;
        chk_rs2 = 5'd7;
        iss_rd  = 5'd5;
        tick();
        checks++;
        if (wr_en !== 1'b0) begin
            errors++; $display("FAIL reset_wr_en got=%0b want=0", wr_en);
        end
        checks++;
        if (wr_addr !== '0 || wr_data !== '0) begin
            errors++; $display("FAIL reset_wr_port got=%0d/%h want=0/0", wr_addr, wr_data);
        end
        checks++;
        if (sb_err !== 1'b0) begin
            errors++; $display("FAIL reset_sb_err got=%0b want=0", sb_err);
        end
        checks++;
        if (s_hazard !== 1'b0 || s_iss_ready !== 1'b1) begin
            errors++; $display("FAIL reset_hazard_ready got=%0b/%0b want=0/1", s_hazard, s_iss_ready);
        end
    endtask

    task automatic test_issue_write();
        bit exp_hz [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        chk_rs1 = 5'd5;
        for (int c = 0; c < 5; c++) begin
            iss_valid = (c == 0);
            iss_rd    = 5'd5;
            a_valid   = (c == 2);
            a_rd      = 5'd5;
            a_data    = 32'hDEADBEEF;
            tick();
            checks++;
            if (s_hazard !== exp_hz[c]) begin
                errors++; $display("FAIL issue_write_hazard c=%0d got=%0b want=%0b", c, s_hazard, exp_hz[c]);
            end
            if (c == 2) begin
                checks++;
                if (s_a_ready !== 1'b1 || wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL issue_write_port got=%0b/%0b/%0d/%h want=1/1/5/deadbeef",
                             s_a_ready, wr_en, wr_addr, wr_data);
                end
            end else begin
                checks++;
                if (wr_en !== 1'b0) begin
                    errors++; $display("FAIL issue_write_idle c=%0d got=%0b want=0", c, wr_en);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int exp_addr [4] = '{1, 2, 1, 2};
        do_reset();
        iss_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            iss_rd = (c < 2) ? 5'd1 : 5'd2;
            tick();
        end
        iss_valid = 1'b0;
        a_valid = 1'b1; a_rd = 5'd1; a_data = 32'hA0A0_0001;
        b_valid = 1'b1; b_rd = 5'd2; b_data = 32'hB0B0_0002;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (s_a_ready !== (c % 2 == 0) || s_b_ready !== (c % 2 == 1)) begin
                errors++;
                $display("FAIL b2b_grant c=%0d got a=%0b b=%0b want a=%0b b=%0b",
                         c, s_a_ready, s_b_ready, (c % 2 == 0), (c % 2 == 1));
            end
            checks++;
            if (wr_en !== 1'b1 || int'(wr_addr) != exp_addr[c]) begin
                errors++;
                $display("FAIL b2b_wr_addr c=%0d got=%0b/%0d want=1/%0d", c, wr_en, wr_addr, exp_addr[c]);
            end
        end
        idle();
        tick();
        checks++;
        if (sb_err !== 1'b0) begin
            errors++; $display("FAIL b2b_sb_err got=%0b want=0", sb_err);
        end
    endtask

    task automatic test_saturate();
        bit exp_rdy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        iss_valid = 1'b1;
        iss_rd    = 5'd7;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (s_iss_ready !== exp_rdy[c]) begin
                errors++; $display("FAIL sat_iss_ready c=%0d got=%0b want=%0b", c, s_iss_ready, exp_rdy[c]);
            end
        end
        // Retire once (3 -> 2), then retire and issue x7 on the same edge (stays 2).
        iss_valid = 1'b0;
        a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h7;
        tick();
        a_valid = 1'b0;
        tick();
        a_valid = 1'b1;
        tick();
        a_valid   = 1'b0;
        iss_valid = 1'b1;
        tick();
        checks++;
        if (s_iss_ready !== 1'b1) begin
            errors++; $display("FAIL sat_same_edge_ready got=%0b want=1", s_iss_ready);
        end
        tick();
        tick();
        checks++;
        if (s_iss_ready !== 1'b0) begin
            errors++; $display("FAIL sat_after_cancel got=%0b want=0", s_iss_ready);
        end
    endtask

    task automatic test_rd0();
        do_reset();
        b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h1234;
        iss_valid = 1'b1; iss_rd = 5'd0;
        tick();
        checks++;
        if (s_b_ready !== 1'b1 || s_iss_ready !== 1'b1) begin
            errors++; $display("FAIL rd0_ready got=%0b/%0b want=1/1", s_b_ready, s_iss_ready);
        end
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== 32'h1234) begin
            errors++; $display("FAIL rd0_wr got=%0b/%0d/%h want=0/0/1234", wr_en, wr_addr, wr_data);
        end
        idle();
        tick();
        checks++;
        if (s_hazard !== 1'b0 || sb_err !== 1'b0) begin
            errors++; $display("FAIL rd0_hazard got=%0b/%0b want=0/0", s_hazard, sb_err);
        end
    endtask

    task automatic test_sb_err();
        do_reset();
        a_valid = 1'b1; a_rd = 5'd9; a_data = 32'h99;
        tick();
        idle();
        tick();
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (sb_err !== 1'b1) begin
                errors++; $display("FAIL sb_err_sticky c=%0d got=%0b want=1", c, sb_err);
            end
        end
        do_reset();
        checks++;
        if (sb_err !== 1'b0) begin
            errors++; $display("FAIL sb_err_cleared got=%0b want=0", sb_err);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        a_valid = 1'b1; b_valid = 1'b1;
        tick();
        idle();
        iss_valid = 1'b1; iss_rd = 5'd3;
        tick();
        tick();
        iss_valid = 1'b0;
        chk_rs1 = 5'd3;
        rst = 1'b1;
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h33;
        b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h44;
        tick();
        checks++;
        if (s_hazard !== 1'b1 || s_a_ready !== 1'b0 || s_b_ready !== 1'b0) begin
            errors++;
            $display("FAIL midflight_rst_cycle got hz=%0b a=%0b b=%0b want 1/0/0", s_hazard, s_a_ready, s_b_ready);
        end
        checks++;
        if (wr_en !== 1'b0) begin
            errors++; $display("FAIL midflight_wr_en got=%0b want=0", wr_en);
        end
        rst = 1'b0;
        a_rd = 5'd0;
        b_rd = 5'd0;
        tick();
        checks++;
        if (s_hazard !== 1'b0 || s_a_ready !== 1'b1 || s_b_ready !== 1'b0) begin
            errors++;
            $display("FAIL midflight_after got hz=%0b a=%0b b=%0b want 0/1/0", s_hazard, s_a_ready, s_b_ready);
        end
        idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 39) == 0);
            iss_valid = $urandom_range(0, 1) == 1;
            iss_rd    = AW'($urandom_range(0, 7));
            a_valid   = $urandom_range(0, 2) == 0;
            a_rd      = AW'($urandom_range(0, 7));
            a_data    = $urandom;
            b_valid   = $urandom_range(0, 2) == 0;
            b_rd      = AW'($urandom_range(0, 7));
            b_data    = $urandom;
            chk_rs1   = AW'($urandom_range(0, 7));
            chk_rs2   = AW'($urandom_range(0, 7));
            tick();
            checks++;
            if (s_iss_ready !== e_iss_ready || s_a_ready !== e_a_ready || s_b_ready !== e_b_ready) begin
                errors++;
                $display("FAIL rand_ready c=%0d got=%0b%0b%0b want=%0b%0b%0b", c,
                         s_iss_ready, s_a_ready, s_b_ready, e_iss_ready, e_a_ready, e_b_ready);
            end
            checks++;
            if (s_hazard !== e_hazard) begin
                errors++; $display("FAIL rand_hazard c=%0d got=%0b want=%0b", c, s_hazard, e_hazard);
            end
            checks++;
            if (wr_en !== m_wr_en || int'(wr_addr) != m_wr_addr || wr_data !== m_wr_data) begin
                errors++;
                $display("FAIL rand_wr c=%0d got=%0b/%0d/%h want=%0b/%0d/%h", c,
                         wr_en, wr_addr, wr_data, m_wr_en, m_wr_addr, m_wr_data);
            end
            checks++;
            if (sb_err !== m_err) begin
                errors++; $display("FAIL rand_sb_err c=%0d got=%0b want=%0b", c, sb_err, m_err);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_issue_write();
        test_back_to_back();
        test_saturate();
        test_rd0();
        test_sb_err();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
